pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Program-counter register and fetch-request controller for the RISC-V core. It holds the architectural PC and drives it to the PC+4 adder and the instruction memory. It takes back the adder's `NextAddr` result and branch/jump redirects, and advances only on an accepted fetch handshake. Optionally, it traps misaligned redirect targets.

## Interface
Parameters:
- `RESET_VECTOR`, `32'h0000_0000`: PC loaded at reset; must be word-aligned.
- `TRAP_VECTOR`, `32'h0000_0100`: PC loaded when a trap is cleared; word-aligned.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `pc_o`, out, 32: current PC, to PC+4 adder `Addr` and to imem address.
- `pc_plus4_i`, in, 32: PC+4 adder `NextAddr`.
- `fetch_valid_o`, out, 1: fetch request for `pc_o` is valid.
- `fetch_ready_i`, in, 1: imem accepts the request.
- `stall_i`, in, 1: suppresses issue of new requests.
- `redirect_valid_i`, in, 1: one-cycle pulse; branch/jump taken.
- `redirect_target_i`, in, 32: redirect target address.
- `trap_o`, out, 1: misaligned-target trap pending (macro only; else tied 0).
- `trap_addr_o`, out, 32: offending target (macro only; else tied 0).
- `trap_clear_i`, in, 1: acknowledge trap (ignored without macro).

## Operation
States:
- BOOT: reset state; `fetch_valid_o` = 0.
- RUN: normal fetching.
- TRAP: trap pending (macro only).

Accept means `fetch_valid_o && fetch_ready_i`.

Transitions and behaviour:
- BOOT→RUN: on the first clock after `rst_n` deasserts. `fetch_valid_o` rises in that same edge if `stall_i`=0.
- Request stability: once `fetch_valid_o`=1, both it and `pc_o` hold until accept. `stall_i` never drops a pending request.
- On accept, the next PC is selected in this priority order: `redirect_target_i` if `redirect_valid_i` is asserted this cycle; else the pending redirect if valid; else `pc_plus4_i`.
  - The pending-redirect register clears on accept.
  - `fetch_valid_o` stays 1 if `stall_i`=0, else it drops to 0.
- Redirect while a request is pending and unaccepted: the target is latched into the pending register. A newer redirect overwrites an older one. `pc_o` is unchanged.
- Redirect while `fetch_valid_o`=0: `pc_o` loads the target at the next edge, and the pending register is cleared.
- Pending redirect with `fetch_valid_o`=0 and no new redirect: `pc_o` loads the pending target before `fetch_valid_o` re-rises.
- While `fetch_valid_o`=0 and `stall_i`=0, `fetch_valid_o` rises at the next edge.
- Arithmetic: none internal; PC+4 comes from the external adder. Wrap from `32'hFFFF_FFFC` to `32'h0000_0000` is accepted silently.

## Timing
- Reset values:
  - `pc_o` = `RESET_VECTOR`.
  - `fetch_valid_o` = 0.
  - `trap_o` = 0.
  - `trap_addr_o` = 0.
  - Pending-redirect register invalid; state BOOT.
- All outputs are registered, with no combinational path from input to output.
- Redirect-to-fetch latency: 1 cycle when idle or at accept. When a request is pending, the redirect takes effect at the edge after accept.
- Back-to-back accepts with `fetch_ready_i`=1 and `stall_i`=0 issue one new PC per cycle.
- Reset mid-request aborts it: all state returns to reset values immediately.

## Configuration
`PC_MISALIGN_TRAP_EN`:
- Defined: a selected next PC with bits [1:0]≠0 is not loaded.
  - The block enters TRAP: `fetch_valid_o`=0, `trap_o`=1, `trap_addr_o`=target, `pc_o` holds its old value.
  - Further redirects are ignored.
  - `trap_clear_i` sets `pc_o`=`TRAP_VECTOR`, `trap_o`=0 and returns to RUN. `fetch_valid_o` rises on the following edge if not stalled.
- Undefined: the target's bits [1:0] are forced to 0 on load, with no TRAP state. `trap_o` and `trap_addr_o` are tied 0.

## Structure
- Shared package `rv_core_pkg`:
  - `XLEN` = 32.
  - State enum `pc_state_t` (BOOT, RUN, TRAP).
  - Default reset and trap vector constants.
- Single module, no sub-module. The pending-redirect register is a valid bit plus 32-bit target inside this module.

## Test plan
- Reset with `RESET_VECTOR`=0, `fetch_ready_i`=1, `stall_i`=0 → `fetch_valid_o` rises the cycle after reset release; `pc_o` sequence is 0, 4, 8, 12 on consecutive cycles.
- `fetch_ready_i`=0 for 3 cycles at PC 8 → `pc_o`=8 and `fetch_valid_o`=1 held all 3 cycles; the next accept gives 12.
- Redirect to `0x40` pulsed while PC 8 is pending and unaccepted, then accept → `pc_o`=`0x40` next cycle, not 12.
- `stall_i`=1 on an accept at PC 4, redirect to `0x80` during the stall, stall released → `fetch_valid_o`=0 during the stall; `pc_o`=`0x80` before `fetch_valid_o` re-rises.
- Macro defined, redirect to `0x102` at accept → `trap_o`=1, `trap_addr_o`=`0x102`, `fetch_valid_o`=0; after `trap_clear_i`, `pc_o`=`0x100`.
- Macro undefined, same stimulus → `pc_o`=`0x100` next cycle and `trap_o` stays 0. Async reset asserted mid-request → `pc_o`=`RESET_VECTOR` and `fetch_valid_o`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core package: datapath width, PC controller state encoding and the
// default reset / trap vectors used by the fetch front end.
package rv_core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC register and fetch-request controller.
// Holds the PC, presents it to the external PC+4 adder and to imem, and only
// advances when the fetch handshake (fetch_valid_o && fetch_ready_i) completes.
// Redirects arriving while a request is outstanding are parked in a one-entry
// pending register and applied at the accept.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned next PC raises a trap (TRAP state) instead of loading
//   undefined : low two bits of a loaded PC are cleared; trap outputs tied 0
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   pc_o                 current PC (adder Addr, imem address)
//   pc_plus4_i           adder NextAddr
//   fetch_valid_o/ready  fetch request handshake
//   stall_i              blocks issue of new requests (never drops a pending one)
//   redirect_valid_i/target_i  branch/jump redirect pulse
//   trap_o, trap_addr_o  misaligned-target trap status
//   trap_clear_i         trap acknowledge
module pc_fetch_ctrl
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            trap_o,
  output logic [XLEN-1:0] trap_addr_o,
  input  logic            trap_clear_i
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            accept;
  logic            load_req;
  logic [XLEN-1:0] load_tgt;

`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
`endif

  assign accept = fv_q & fetch_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fv_d       = fv_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    load_req   = 1'b0;
    load_tgt   = '0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
`endif

    case (state_q)
      // BOOT behaves as an idle RUN cycle so the first edge after reset
      // release already raises the request.
      BOOT, RUN: begin
        state_d = RUN;
        if (accept) begin
          // A redirect in the accept cycle is newer than anything parked.
          load_req   = 1'b1;
          load_tgt   = redirect_valid_i ? redirect_target_i :
                       pend_vld_q       ? pend_tgt_q        : pc_plus4_i;
          pend_vld_d = 1'b0;
          fv_d       = ~stall_i;
        end else if (fv_q) begin
          // Request outstanding: PC must stay stable, park the redirect.
          if (redirect_valid_i) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redirect_target_i;
          end
        end else begin
          // Idle: a redirect (or a parked one) loads straight into the PC,
          // in the same edge the request may re-rise.
          if (redirect_valid_i) begin
            load_req = 1'b1;
            load_tgt = redirect_target_i;
          end else if (pend_vld_q) begin
            load_req = 1'b1;
            load_tgt = pend_tgt_q;
          end
          pend_vld_d = 1'b0;
          fv_d       = ~stall_i;
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      TRAP: begin
        // Redirects are dropped while the trap is pending.
        fv_d       = 1'b0;
        pend_vld_d = 1'b0;
        if (trap_clear_i) begin
          pc_d    = TRAP_VECTOR;
          trap_d  = 1'b0;
          state_d = RUN;
        end
      end
`endif
      default: begin
        state_d = BOOT;
        fv_d    = 1'b0;
      end
    endcase

    if (load_req) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (|load_tgt[1:0]) begin
        state_d     = TRAP;
        fv_d        = 1'b0;
        trap_d      = 1'b1;
        trap_addr_d = load_tgt;
      end else begin
        pc_d = load_tgt;
      end
`else
      pc_d = load_tgt & ~32'h3;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      fv_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fv_q       <= fv_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fv_q;

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign trap_o      = trap_q;
  assign trap_addr_o = trap_addr_q;
`else
  assign trap_o      = 1'b0;
  assign trap_addr_o = '0;

  // Trap inputs/vector have no function without the trap feature.
  logic unused_trap_cfg;
  assign unused_trap_cfg = ^{TRAP_VECTOR, trap_clear_i};
`endif

endmodule
